sha256_round_core: RTL
======================

// Module: sha256_round_core
// PURPOSE
//  SHA-256 compression engine, one round per clock, with an on-the-fly message schedule.
//  Sits directly upstream of the H0..H7 chaining accumulators and drives their 'b' inputs.
//  Loads a 512-bit block and a 256-bit chaining value, runs 64 rounds, then presents the
//  final working variables a..h. The accumulators add these to H and advance Block 0->1->2.
// PARAMETERS
//  ROUNDS     64  rounds per block; fixed by FIPS 180-4, exposed for bench shortening only
//  CNT_W      6   width of round counter t; holds ROUNDS-1
// PORTS
//  clk        in   1    single clock, rising edge
//  rst_n      in   1    asynchronous active-low reset
//  start      in   1    request; sampled only in IDLE
//  blk_in     in   512  message block; W0 = blk_in[511:480], W15 = blk_in[31:0]
//  iv_in      in   256  chaining value {H0..H7}; H0 in bits [255:224]
//  busy       out  1    high from accepted start until the done cycle (inclusive)
//  done       out  1    one-cycle pulse; state_out is valid on this cycle
//  state_out  out  256  {a,b,c,d,e,f,g,h}; a in [255:224]; held until next accepted start
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, t=0, a..h=0, W window=0, busy=0, done=0, state_out=0.
//  FSM: IDLE -> ROUND -> DONE -> IDLE.
//   IDLE : on start=1 at edge N, load a..h<=iv_in and W[0..15]<=blk_in, set t=0, go to ROUND.
//          busy=1 from edge N.
//   ROUND: each edge applies round t with K[t] and W[t], then increments t.
//          At t=ROUNDS-1, the edge applies the final round and moves to DONE.
//          Rounds occupy edges N+1..N+64.
//   DONE : done=1 and busy=1 for exactly one cycle (after edge N+64). Return to IDLE next edge.
//  Latency: done is high in the 65th cycle after the start edge. Next start is accepted at
//  edge N+66 at the earliest.
//  Round math (mod 2^32, all adds wrap; carries discarded):
//   T1 = h + S1(e) + Ch(e,f,g) + K[t] + W[t]
//   T2 = S0(a) + Maj(a,b,c)
//   h<=g, g<=f, f<=e, e<=d+T1, d<=c, c<=b, b<=a, a<=T1+T2
//  Schedule: 16-word shift window w[0..15], where w[0] is the current W[t].
//   Each round, shift by one and append s1(w[14]) + w[9] + s0(w[1]) + w[0].
//   For t<16 the appended word is computed but is exactly W[t+16]; no special case is needed.
//  start while busy/DONE: ignored, with no effect on the running block.
//  start held high through DONE: the core re-launches in the following IDLE cycle using the
//   current blk_in/iv_in.
//  blk_in/iv_in are sampled only at the accepting edge; later changes are ignored.
//  state_out is registered; it updates only at the edge entering DONE, otherwise it holds.
//  rst_n low mid-block: immediate abort to reset values, with no done pulse; the next start
//   runs cleanly.
// STRUCTURE
//  sha256_pkg: K[0..63] table, IV constants (6a09e667, bb67ae85, ...), functions S0/S1/s0/s1/
//   Ch/Maj, and FSM state encodings (IDLE=2'd0, ROUND=2'd1, DONE=2'd2).
//  Sub-module sha256_k_rom: combinational 64x32 lookup, idx[5:0] -> k[31:0].
//  Remaining logic is flat in this module: FSM, t counter, a..h registers, and the W window.
// TESTING
//  1 "abc" block (61626380, 0 x14, 00000018), standard IV -> state_out = 506e3058 d39a2165
//    04d24d6c b85e2ce9 5ef50f24 fb121210 948d25b6 961f4894.
//    Adding the IV must give ba7816bf... .
//  2 Latency: start at edge N -> done=1 only in the cycle after edge N+64.
//    busy=1 from N through the done cycle; busy=0 and done=0 the cycle after.
//  3 start pulsed at t=10 and again in the DONE cycle -> both are ignored.
//    Exactly one done, and the result equals scenario 1.
//  4 rst_n low at t=30 -> busy=0, done=0, state_out=0 at once, with no done pulse.
//    A fresh "abc" start then yields the scenario-1 values.
//  5 Two-block chain: start, then at done feed blk2 with iv = IV + state_out.
//    Compare against the C model for message "a"x64, result 0xffe054fe... .
//  6 Random blocks/IVs (>=200), start held high continuously.
//    Every result must match the C model, and consecutive done pulses must be exactly
//    66 cycles apart.

Source files
------------

// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - SHA-256 round constants, IV, mixing functions and FSM encodings
package sha256_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [31:0] K_TAB [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_s0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_s1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// rtl/sha256_k_rom.sv - combinational 64x32 round-constant lookup
module sha256_k_rom
  import sha256_pkg::*;
(
  input  logic [5:0]  idx,
  output logic [31:0] k
);

  assign k = K_TAB[idx];

endmodule

// File: rtl/sha256_round_core.sv
// rtl/sha256_round_core.sv - SHA-256 compression, one round per clock, rolling W window
module sha256_round_core
  import sha256_pkg::*;
#(
  parameter int ROUNDS = 64,
  parameter int CNT_W  = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [511:0] blk_in,
  input  logic [255:0] iv_in,
  output logic         busy,
  output logic         done,
  output logic [255:0] state_out
);

  state_t            state;
  logic [CNT_W-1:0]  t;
  logic [31:0]       a, b, c, d, e, f, g, h;
  logic [31:0]       w [0:15];
  logic [31:0]       k_t, t1, t2, a_nxt, e_nxt, w_new;

  sha256_k_rom u_k_rom (
    .idx (6'(t)),
    .k   (k_t)
  );

  assign t1    = h + big_s1(e) + ch(e, f, g) + k_t + w[0];
  assign t2    = big_s0(a) + maj(a, b, c);
  assign a_nxt = t1 + t2;
  assign e_nxt = d + t1;
  // Word appended to the window is W[t+16]; early rounds need no special case.
  assign w_new = small_s1(w[14]) + w[9] + small_s0(w[1]) + w[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      t         <= '0;
      {a, b, c, d, e, f, g, h} <= '0;
      for (int i = 0; i < 16; i++) w[i] <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      state_out <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            {a, b, c, d, e, f, g, h} <= iv_in;
            for (int i = 0; i < 16; i++) w[i] <= blk_in[511-32*i -: 32];
            t     <= '0;
            busy  <= 1'b1;
            state <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          {a, b, c, d, e, f, g, h} <= {a_nxt, a, b, c, e_nxt, e, f, g};
          for (int i = 0; i < 15; i++) w[i] <= w[i+1];
          w[15] <= w_new;
          t     <= t + 1'b1;
          if (t == CNT_W'(ROUNDS - 1)) begin
            t         <= '0;
            done      <= 1'b1;
            state_out <= {a_nxt, a, b, c, e_nxt, e, f, g};
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
